d_cache_tag_ctrl: RTL and testbench

Lookup and refill controller that sits directly upstream of `d_cache_tag_ram` in the data cache. It accepts CPU load/store requests and drives the tag RAM's address, write data and write enable. It compares the tag RAM's registered output against the request tag, runs the miss/refill handshake with the memory-side refill engine, and installs new tags. It also invalidates all 64 sets automatically after reset and on a flush request.

---
 rtl/d_cache_pkg.sv | 40 ++++
 rtl/d_cache_tag_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_d_cache_tag_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_pkg.sv
// -----------------------------------------------------------------------------
// d_cache_pkg
// Shared definitions for the data-cache controllers (tag and data side).
//   INDEX_W  : set index width (64 sets)
//   TAG_W    : tag width (address bits [63:9])
//   OFFSET_W : byte offset within an 8-byte line
//   d_cache_ctrl_state_t : controller state encoding
//   tag_entry_t          : one tag RAM word, {valid, tag}
// -----------------------------------------------------------------------------
package d_cache_pkg;

  localparam int INDEX_W  = 6;
  localparam int TAG_W    = 55;
  localparam int OFFSET_W = 3;
  localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [2:0] {
    ST_FLUSH       = 3'd0,
    ST_IDLE        = 3'd1,
    ST_LOOKUP      = 3'd2,
    ST_MISS_REQ    = 3'd3,
    ST_REFILL_WAIT = 3'd4,
    ST_TAG_WRITE   = 3'd5,
    ST_RESP        = 3'd6
  } d_cache_ctrl_state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  // Build the tag RAM word that marks a line as present.
  function automatic tag_entry_t make_valid_entry(input logic [TAG_W-1:0] tag);
    tag_entry_t e;
    e.valid = 1'b1;
    e.tag   = tag;
    return e;
  endfunction

endpackage

// File: rtl/d_cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// d_cache_tag_ctrl
// Lookup/refill controller in front of d_cache_tag_ram. Accepts CPU requests,
// reads the tag RAM, compares against the request tag, runs the refill
// handshake on a miss and installs the new tag. Invalidates all sets after
// reset and on a flush request.
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o       : CPU request handshake
//   req_addr_i[63:0], req_we_i    : byte address (index [8:3], tag [63:9]), store flag
//   resp_valid_o, resp_hit_o      : one-cycle response, 1 = original lookup hit
//   refill_req_o/refill_ack_i     : refill request held until acknowledged
//   refill_addr_o[63:0]           : line-aligned miss address
//   refill_done_i                 : refill line written (pulse)
//   flush_i, flush_done_o         : invalidate-all request / completion pulse
//   tag_addr_o, tag_wdata_o, tag_we_o : tag RAM address, {valid,tag}, write enable
//   tag_data_i, tag_valid_i       : tag RAM registered read data
//   hit_cnt_o, miss_cnt_o         : saturating response counters
//                                   (only with D_CACHE_TAG_CTRL_STAT_EN defined)
//
// Optional feature macro: D_CACHE_TAG_CTRL_STAT_EN
// -----------------------------------------------------------------------------
module d_cache_tag_ctrl #(
  parameter int INDEX_W = d_cache_pkg::INDEX_W,
  parameter int TAG_W   = d_cache_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [63:0]        req_addr_i,
  input  logic               req_we_i,
  output logic               resp_valid_o,
  output logic               resp_hit_o,
  output logic               refill_req_o,
  output logic [63:0]        refill_addr_o,
  input  logic               refill_ack_i,
  input  logic               refill_done_i,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic [INDEX_W-1:0] tag_addr_o,
  output logic [TAG_W:0]     tag_wdata_o,
  output logic               tag_we_o,
`ifdef D_CACHE_TAG_CTRL_STAT_EN
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o,
`endif
  input  logic [TAG_W-1:0]   tag_data_i,
  input  logic               tag_valid_i
);

  import d_cache_pkg::*;

  d_cache_ctrl_state_t r_state;
  d_cache_ctrl_state_t w_state_next;

  // One extra counter bit: values 0..63 are the invalidate writes, 64 is the
  // completion cycle that pulses flush_done_o.
  logic [INDEX_W:0]   r_cnt;
  logic [INDEX_W-1:0] r_idx;
  logic [TAG_W-1:0]   r_tag;
  logic               r_hit;
  logic               r_flush_pend;
  logic [INDEX_W-1:0] r_tag_addr;    // last address presented to the tag RAM

  logic [INDEX_W-1:0] w_tag_addr;
  logic               w_handshake;
  logic               w_lookup_hit;
  tag_entry_t         w_new_entry;

  // Loads and stores both allocate, so the store flag and the byte offset do
  // not influence tag handling.
  logic w_unused;
  assign w_unused = ^{req_we_i, req_addr_i[OFFSET_W-1:0]};

  assign w_lookup_hit  = tag_valid_i && (tag_data_i == r_tag);
  assign w_new_entry   = make_valid_entry(r_tag);
  assign refill_addr_o = {r_tag, r_idx, {OFFSET_W{1'b0}}};
  assign tag_addr_o    = w_tag_addr;

  always_comb begin
    w_state_next = r_state;
    w_tag_addr   = r_tag_addr;
    w_handshake  = 1'b0;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_hit_o   = 1'b0;
    refill_req_o = 1'b0;
    flush_done_o = 1'b0;
    tag_we_o     = 1'b0;
    tag_wdata_o  = '0;

    case (r_state)
      ST_FLUSH: begin
        if (!r_cnt[INDEX_W]) begin
          tag_we_o   = 1'b1;
          w_tag_addr = r_cnt[INDEX_W-1:0];
        end else begin
          flush_done_o = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A flush in this cycle takes priority, so the request must not see ready.
        req_ready_o = !r_flush_pend && !flush_i;
        if (flush_i || r_flush_pend) begin
          w_state_next = ST_FLUSH;
        end else if (req_valid_i) begin
          w_handshake  = 1'b1;
          w_tag_addr   = req_addr_i[OFFSET_W +: INDEX_W];
          w_state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        w_state_next = w_lookup_hit ? ST_RESP : ST_MISS_REQ;
      end
      ST_MISS_REQ: begin
        refill_req_o = 1'b1;
        if (refill_ack_i) begin
          w_state_next = refill_done_i ? ST_TAG_WRITE : ST_REFILL_WAIT;
        end
      end
      ST_REFILL_WAIT: begin
        if (refill_done_i) begin
          w_state_next = ST_TAG_WRITE;
        end
      end
      ST_TAG_WRITE: begin
        tag_we_o     = 1'b1;
        w_tag_addr   = r_idx;
        tag_wdata_o  = w_new_entry;
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = r_hit;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FLUSH;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_tag        <= '0;
      r_hit        <= 1'b0;
      r_flush_pend <= 1'b0;
      r_tag_addr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tag_addr <= w_tag_addr;

      if (r_state == ST_FLUSH) begin
        r_cnt <= r_cnt[INDEX_W] ? '0 : r_cnt + 1'b1;
      end

      if (w_handshake) begin
        r_idx <= req_addr_i[OFFSET_W +: INDEX_W];
        r_tag <= req_addr_i[OFFSET_W+INDEX_W +: TAG_W];
      end

      // A miss leaves r_hit at 0, which is what the post-refill response reports.
      if (r_state == ST_LOOKUP) begin
        r_hit <= w_lookup_hit;
      end

      // IDLE always consumes a pending flush by entering FLUSH; a flush that
      // arrives while FLUSH is running has nothing left to do.
      if (r_state == ST_IDLE) begin
        r_flush_pend <= 1'b0;
      end else if (r_state != ST_FLUSH && flush_i) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

`ifdef D_CACHE_TAG_CTRL_STAT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == ST_RESP) begin
      if (r_hit && !(&r_hit_cnt)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (!r_hit && !(&r_miss_cnt)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_d_cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_d_cache_tag_ctrl
// Bench for d_cache_tag_ctrl with a behavioural tag RAM, a reference cache
// directory (valid/tag per set) and cycle expectations derived from the
// lookup / refill / flush rules.
// -----------------------------------------------------------------------------
module tb_d_cache_tag_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        req_we_i;
  logic        resp_valid_o;
  logic        resp_hit_o;
  logic        refill_req_o;
  logic [63:0] refill_addr_o;
  logic        refill_ack_i;
  logic        refill_done_i;
  logic        flush_i;
  logic        flush_done_o;
  logic [5:0]  tag_addr_o;
  logic [55:0] tag_wdata_o;
  logic        tag_we_o;
  logic [54:0] tag_data_i;
  logic        tag_valid_i;
`ifdef D_CACHE_TAG_CTRL_STAT_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  d_cache_tag_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_we_i     (req_we_i),
    .resp_valid_o (resp_valid_o),
    .resp_hit_o   (resp_hit_o),
    .refill_req_o (refill_req_o),
    .refill_addr_o(refill_addr_o),
    .refill_ack_i (refill_ack_i),
    .refill_done_i(refill_done_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .tag_addr_o   (tag_addr_o),
    .tag_wdata_o  (tag_wdata_o),
    .tag_we_o     (tag_we_o),
`ifdef D_CACHE_TAG_CTRL_STAT_EN
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o),
`endif
    .tag_data_i   (tag_data_i),
    .tag_valid_i  (tag_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural tag RAM: write-through on we, otherwise registered read.
  logic [55:0] ram [64];
  always @(posedge clk) begin
    if (tag_we_o) ram[tag_addr_o] <= tag_wdata_o;
    else {tag_valid_i, tag_data_i} <= ram[tag_addr_o];
  end

  // Reference directory and expected counters.
  bit          ref_valid [64];
  logic [54:0] ref_tag   [64];
  int          exp_hits;
  int          exp_misses;

  int checks;
  int errors;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic bit ref_hit(logic [63:0] a);
    return ref_valid[a[8:3]] && (ref_tag[a[8:3]] == a[63:9]);
  endfunction

  function automatic void ref_invalidate();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endfunction

  // Reset is already asserted on entry; checks reset values, releases reset
  // and walks the 64 invalidate writes, the done pulse and the first ready.
  task automatic reset_seq();
    @(posedge clk); #1;
    chk("rst_req_ready",   64'(req_ready_o),   64'(0));
    chk("rst_resp_valid",  64'(resp_valid_o),  64'(0));
    chk("rst_resp_hit",    64'(resp_hit_o),    64'(0));
    chk("rst_refill_req",  64'(refill_req_o),  64'(0));
    chk("rst_refill_addr", refill_addr_o,      64'(0));
    chk("rst_flush_done",  64'(flush_done_o),  64'(0));
    chk("rst_tag_we",      64'(tag_we_o),      64'(1));
    chk("rst_tag_addr",    64'(tag_addr_o),    64'(0));
    chk("rst_tag_wdata",   64'(tag_wdata_o),   64'(0));
    rst = 1'b0;
    for (int j = 0; j <= 65; j++) begin
      if (j == 0) #1;
      else begin @(posedge clk); #2; end
      chk("init_tag_we", 64'(tag_we_o), 64'(j < 64));
      if (j < 64) begin
        chk("init_tag_addr",  64'(tag_addr_o),  64'(j));
        chk("init_tag_wdata", 64'(tag_wdata_o), 64'(0));
      end
      chk("init_flush_done", 64'(flush_done_o), 64'(j == 64));
      chk("init_req_ready",  64'(req_ready_o),  64'(j == 65));
    end
    ref_invalidate();
    $display("TXN reset flush complete at cycle 65");
  endtask

  // Issue one request and follow it cycle by cycle. Cycle 0 is the handshake
  // cycle; a hit responds in cycle 2, a miss requests refill from cycle 2 until
  // the ack (cycle 2+a), sees done at cycle 2+a+d, writes the tag in the cycle
  // after done and responds one cycle later.
  task automatic do_req(input logic [63:0] addr, input int a, input int d,
                        input bit exp_hit, input int flush_k, input int exp_wait);
    int          waited;
    bit          got;
    int          tw;
    int          rs;
    bit          e_req;
    bit          e_tw;
    bit          we;
    logic        seen_hit;
    logic [5:0]  idx;
    logic [54:0] tg;
    idx = addr[8:3];
    tg  = addr[63:9];
    we  = 1'($urandom_range(0, 1));
    got = 1'b0;
    waited = 0;
    seen_hit = 1'b0;
    while (!got && waited < 200) begin
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we;
      flush_i = 1'b0; refill_ack_i = 1'b0; refill_done_i = 1'b0;
      #1;
      if (req_ready_o) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      chk("req_accept_timeout", 64'(0), 64'(1));
      req_valid_i = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk("req_wait_cycles", 64'(waited), 64'(exp_wait));
    chk("hs_tag_addr", 64'(tag_addr_o), 64'(idx));
    chk("hs_tag_we",   64'(tag_we_o),   64'(0));
    tw = 2 + a + d + 1;
    rs = exp_hit ? 2 : tw + 1;
    for (int k = 1; k <= rs; k++) begin
      @(posedge clk); #1;
      req_valid_i   = 1'b0;
      refill_ack_i  = !exp_hit && (k == 2 + a);
      refill_done_i = !exp_hit && (k == 2 + a + d);
      flush_i       = (k == flush_k);
      #1;
      e_req = !exp_hit && (k >= 2) && (k <= 2 + a);
      e_tw  = !exp_hit && (k == tw);
      chk("refill_req", 64'(refill_req_o), 64'(e_req));
      if (e_req) chk("refill_addr", refill_addr_o, {addr[63:3], 3'b000});
      chk("tag_we", 64'(tag_we_o), 64'(e_tw));
      if (e_tw) begin
        chk("tag_write_addr", 64'(tag_addr_o),  64'(idx));
        chk("tag_write_data", 64'(tag_wdata_o), 64'({1'b1, tg}));
      end
      chk("resp_valid", 64'(resp_valid_o), 64'(k == rs));
      if (k == rs) begin
        chk("resp_hit", 64'(resp_hit_o), 64'(exp_hit));
        seen_hit = resp_hit_o;
      end
      chk("busy_req_ready", 64'(req_ready_o),  64'(0));
      chk("busy_flush_done", 64'(flush_done_o), 64'(0));
    end
    flush_i = 1'b0;
    if (exp_hit) exp_hits++;
    else begin
      exp_misses++;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
    end
    $display("TXN addr=%016h we=%0d ack_dly=%0d done_dly=%0d exp_hit=%0d resp_hit=%0d wait=%0d",
             addr, we, a, d, exp_hit, seen_hit, waited);
  endtask

  // Flush walk starting in an IDLE cycle that will enter FLUSH (pending flag,
  // or a flush_i pulse driven here). A request is held throughout and must
  // not be accepted; a second flush_i during FLUSH must have no effect.
  task automatic check_flush(input bit pulse, input logic [63:0] hold_addr);
    for (int k = 0; k <= 65; k++) begin
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_addr_i = hold_addr;
      refill_ack_i = 1'b0; refill_done_i = 1'b0;
      flush_i = (k == 0 && pulse) || (k == 10);
      #1;
      chk("flush_req_ready", 64'(req_ready_o), 64'(0));
      chk("flush_tag_we", 64'(tag_we_o), 64'(k >= 1 && k <= 64));
      if (k >= 1 && k <= 64) begin
        chk("flush_tag_addr",  64'(tag_addr_o),  64'(k - 1));
        chk("flush_tag_wdata", 64'(tag_wdata_o), 64'(0));
      end
      chk("flush_done", 64'(flush_done_o), 64'(k == 65));
      chk("flush_resp_valid", 64'(resp_valid_o), 64'(0));
    end
    flush_i = 1'b0;
    ref_invalidate();
    $display("TXN flush pulse=%0d complete, request held", pulse);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          a_dly;
    int          d_dly;
    bit          exp_hit;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra;
    logic [54:0] rt;
    logic [5:0]  ri;
    int          waited;

    checks = 0; errors = 0; exp_hits = 0; exp_misses = 0;
    rst = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
    refill_ack_i = 1'b0; refill_done_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] <= 56'({$urandom(), $urandom()});

    vecs[0] = '{64'h0000_0000_0000_1238,  0, 0, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_1238,  0, 0, 1'b1};
    vecs[2] = '{64'h0000_0000_0000_3238,  1, 2, 1'b0};
    vecs[3] = '{64'h0000_0000_0000_1238,  0, 3, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_1238,  0, 0, 1'b1};
    vecs[5] = '{64'h8000_0000_0000_1238, 10, 1, 1'b0};
    vecs[6] = '{64'h0000_0000_0000_0040,  2, 0, 1'b0};
    vecs[7] = '{64'h0000_0000_0000_0044,  0, 0, 1'b1};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFF8,  0, 1, 1'b0};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFF8,  0, 0, 1'b1};

    reset_seq();

    for (int v = 0; v < 10; v++) begin
      do_req(vecs[v].addr, vecs[v].a_dly, vecs[v].d_dly, vecs[v].exp_hit, -1, 0);
    end

    // Flush during REFILL_WAIT: the refill finishes, then FLUSH runs.
    do_req(64'h0000_0000_0000_3238, 0, 5, 1'b0, 4, 0);
    check_flush(1'b0, 64'h0000_0000_0000_3238);
    do_req(64'h0000_0000_0000_3238, 0, 0, 1'b0, -1, 0);

    // Flush pulse in IDLE beats a simultaneous request.
    check_flush(1'b1, 64'h0000_0000_0000_3238);
    do_req(64'h0000_0000_0000_3238, 1, 1, 1'b0, -1, 0);

    for (int n = 0; n < 40; n++) begin
      ri = 6'($urandom_range(0, 3));
      rt = 55'($urandom_range(0, 2));
      ra = {rt, ri, 3'($urandom_range(0, 7))};
      do_req(ra, $urandom_range(0, 3), $urandom_range(0, 3), ref_hit(ra), -1, 0);
    end

`ifdef D_CACHE_TAG_CTRL_STAT_EN
    #1;
    chk("hit_cnt",  64'(hit_cnt_o),  64'(exp_hits));
    chk("miss_cnt", 64'(miss_cnt_o), 64'(exp_misses));
`endif

    // Reset asserted while a refill request is outstanding.
    ra = 64'hABCD_0000_0000_0140;
    waited = 0;
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_addr_i = ra;
    #1;
    while (!req_ready_o && waited < 200) begin
      @(posedge clk); #2;
      waited++;
    end
    chk("midrst_accept", 64'(req_ready_o), 64'(1));
    @(posedge clk); #1; req_valid_i = 1'b0; #1;
    @(posedge clk); #2;
    chk("midrst_refill_req_before", 64'(refill_req_o), 64'(1));
    #3 rst = 1'b1;
    #1;
    chk("midrst_refill_req_async", 64'(refill_req_o), 64'(0));
    chk("midrst_req_ready",        64'(req_ready_o),  64'(0));
    chk("midrst_tag_we",           64'(tag_we_o),     64'(1));
`ifdef D_CACHE_TAG_CTRL_STAT_EN
    chk("midrst_hit_cnt",  64'(hit_cnt_o),  64'(0));
    chk("midrst_miss_cnt", 64'(miss_cnt_o), 64'(0));
`endif
    reset_seq();
    do_req(ra, 0, 0, 1'b0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
